// File: rtl/display_scheduler.sv
// display_scheduler: round-robin owner of the shared 8-digit display.
// Captures one requester's binary value, converts it to packed BCD with a
// sequential shift-and-add-3 pass, then holds the result for HOLD_CYCLES.
//
// state | meaning
// IDLE  | display free, arbitrating among pending requests
// CONV  | 32 double-dabble iterations on the captured value
// SHOW  | result held for HOLD_CYCLES, requests ignored
module display_scheduler #(
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [95:0] value_in,
   output logic [2:0]  ack,
   output logic [31:0] bcd_out,
   output logic        bcd_valid,
   output logic [1:0]  owner,
   output logic        ovf,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

   localparam logic [31:0] CONV_LOAD = 32'd31;
   localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] BCD_MAX   = 32'd99_999_999;

   state_t      state;
   logic [1:0]  rr_ptr;
   logic [31:0] cnt;
   logic [39:0] acc;
   logic [31:0] bin;

   logic [1:0]  win;
   logic [31:0] win_value;
   logic [39:0] acc_adj;
   logic [71:0] shifted;

   // Round-robin search starting at rr_ptr; only meaningful when |req.
   always_comb begin
      win = 2'd0;
      case (rr_ptr)
         2'd1: begin
            if (req[1])      win = 2'd1;
            else if (req[2]) win = 2'd2;
            else             win = 2'd0;
         end
         2'd2: begin
            if (req[2])      win = 2'd2;
            else if (req[0]) win = 2'd0;
            else             win = 2'd1;
         end
         default: begin
            if (req[0])      win = 2'd0;
            else if (req[1]) win = 2'd1;
            else             win = 2'd2;
         end
      endcase
   end

   // Select the winner's 32-bit slice.
   always_comb begin
      case (win)
         2'd1:    win_value = value_in[63:32];
         2'd2:    win_value = value_in[95:64];
         default: win_value = value_in[31:0];
      endcase
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin}.
   always_comb begin
      acc_adj = acc;
      for (int d = 0; d < 10; d++) begin
         if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
   end

   assign shifted = {acc_adj, bin} << 1;

   // Sequencer: arbitration, conversion and hold timing with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= 2'd0;
         cnt       <= 32'd0;
         acc       <= 40'd0;
         bin       <= 32'd0;
         ack       <= 3'b000;
         bcd_out   <= 32'd0;
         bcd_valid <= 1'b0;
         owner     <= 2'b11;
         ovf       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ack <= 3'b000;
         case (state)
            IDLE: begin
               if (|req) begin
                  bin       <= win_value;
                  acc       <= 40'd0;
                  ovf       <= (win_value > BCD_MAX);
                  owner     <= win;
                  ack       <= 3'b001 << win;
                  rr_ptr    <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                  cnt       <= CONV_LOAD;
                  bcd_valid <= 1'b0;
                  busy      <= 1'b1;
                  state     <= CONV;
               end
            end
            CONV: begin
               acc <= shifted[71:32];
               bin <= shifted[31:0];
               if (cnt == 32'd0) begin
                  bcd_out   <= ovf ? 32'h9999_9999 : shifted[63:32];
                  bcd_valid <= 1'b1;
                  cnt       <= HOLD_LOAD;
                  state     <= SHOW;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            SHOW: begin
               if (cnt == 32'd0) begin
                  owner <= 2'b11;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Shares the 8-digit seven-segment display between three requesters. Round-robin arbiter grants the display to one requester at a time and captures its 32-bit binary value. A sequential shift-and-add-3 (double-dabble) converter turns that value into packed BCD. The BCD is held for a programmable time. Sits between the result-producing logic and the digit multiplexer, which consumes `bcd_out` directly and no longer needs per-digit division.

## Interface

- `HOLD_CYCLES`, default 100_000_000 — cycles a granted value is shown before re-arbitration; minimum 1.
- `clk` in 1 — system clock; all logic on rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `req` in 3 — request per requester; level, held until `ack`.
- `value_in` in 96 — requester i value at `[32*i+31:32*i]`, unsigned binary.
- `ack` out 3 — one-cycle pulse to the requester whose value was captured.
- `bcd_out` out 32 — 8 packed BCD digits; digit 7 (most significant) at `[31:28]`, digit 0 at `[3:0]`.
- `bcd_valid` out 1 — `bcd_out` holds a completed conversion.
- `owner` out 2 — index of the requester currently owning the display; 2'b11 when none.
- `ovf` out 1 — captured value exceeded 99_999_999.
- `busy` out 1 — high in CONV and SHOW.

## Operation

- **States:** IDLE, CONV, SHOW.
- **IDLE:**
  - If `req` is 0, stay in IDLE.
  - Otherwise pick a winner by round-robin, starting at pointer `rr_ptr` and searching `rr_ptr`, `rr_ptr+1`, `rr_ptr+2` modulo 3.
  - Capture the winner's `value_in` slice, set `owner`, set `rr_ptr` = winner+1 mod 3, and go to CONV.
- **CONV:**
  - Lasts exactly 32 cycles.
  - Each cycle adds 3 to every 4-bit digit of the 40-bit BCD accumulator whose value is ≥5, then shifts {bcd, bin} left by 1.
  - Accumulator is cleared on entry.
  - `bcd_valid` is 0 throughout CONV.
  - After the 32nd iteration, `bcd_out` loads accumulator `[31:0]`, or 32'h9999_9999 if `ovf`. Then `bcd_valid` goes to 1 and the state goes to SHOW.
- **ovf:** computed at capture as value > 99_999_999. It is held until the next capture.
- **SHOW:**
  - Down-counter loaded with HOLD_CYCLES-1 on entry.
  - Transition to IDLE when the counter reaches 0 in SHOW.
  - Requests are ignored during SHOW; no preemption.
- **On return to IDLE:**
  - `owner` goes to 2'b11.
  - `bcd_out`, `bcd_valid` and `ovf` keep their last values, so the display keeps showing the last number.
- **Requester obligations:** a requester must drop `req` after `ack`. A `req` still high is treated as a new request at the next arbitration.
- **Value stability:** `value_in` changes after capture do not affect the conversion in progress.
- **Reset values:**
  - Outputs: `ack`=0, `bcd_out`=0, `bcd_valid`=0, `owner`=2'b11, `ovf`=0, `busy`=0.
  - Internal: state IDLE, `rr_ptr`=0, counters 0.
- **Reset mid-operation:** reset in any state returns all of the above to reset values at the next edge. A partial conversion is discarded and no `ack` is issued for it.

## Timing

- `req` sampled high in IDLE at edge t:
  - CONV entered at t+1; `ack[winner]` high during cycle t+1 only; `busy` high from t+1.
  - CONV occupies cycles t+1..t+32.
  - `bcd_out`, `bcd_valid`=1 and SHOW take effect at t+33.
  - IDLE is re-entered at t+33+HOLD_CYCLES; `busy`=0 in that cycle.
- **Back-to-back requests:** earliest next capture is the edge at t+33+HOLD_CYCLES (arbitration happens in the first IDLE cycle). Best-case period per displayed value is 33+HOLD_CYCLES cycles.
- **Simultaneous requests:** resolved purely by `rr_ptr`. No requester waits more than two grants.
- `ack`, `owner`, `bcd_out` and `bcd_valid` are registered; no combinational path from `req` or `value_in` to any output.

## Test plan

1. Reset, then `req`=3'b001 with value0=12_345_678 → `ack`=3'b001 one cycle after sample; `bcd_valid` rises 33 cycles after sample with `bcd_out`=32'h1234_5678, `ovf`=0, `owner`=0.
2. Simultaneous `req`=3'b111 held continuously with HOLD_CYCLES=4 → grant order 0,1,2,0; consecutive `ack` pulses exactly 37 cycles apart; each value shown for 4 cycles.
3. value=0 → `bcd_out`=0. value=99_999_999 → 32'h9999_9999 with `ovf`=0. value=100_000_000 → 32'h9999_9999 with `ovf`=1. value=32'hFFFF_FFFF → `ovf`=1.
4. `value_in` changed 5 cycles after capture → `bcd_out` reflects the captured value, not the new one.
5. Assert `reset` at cycle 10 of CONV → next edge shows all outputs at reset values and state IDLE. A re-issued request then converts correctly from scratch, with `rr_ptr` back at 0.
6. `req` dropped to 0 after SHOW → return to IDLE; `owner`=2'b11, `busy`=0, `bcd_valid`=1 and `bcd_out` retained indefinitely.
